fetch_queue: RTL

//  Parametrised instruction fetch buffer between program ROM and decode.
//  - Replaces the single 8-bit fetch register with a DEPTH-entry FIFO.
//  - Adds a valid/ready handshake on both sides, a branch flush and a

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between program ROM, fetch queue and decode.
// The slave modport is the queue; the master modport is the ROM/decode side.
interface fetch_queue_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] Data;
    logic              DataValid;
    logic              Ready;
    logic [DATA_W-1:0] Q;
    logic              QValid;
    logic              Take;
    logic              FLUSH;
    logic [ADDR_W-1:0] FLUSH_ADDR;
    logic [ADDR_W-1:0] FETCH_ADDR;
    logic [LVL_W-1:0]  LEVEL;

    modport master (
        output Data, DataValid, Take, FLUSH, FLUSH_ADDR,
        input  Ready, Q, QValid, FETCH_ADDR, LEVEL
    );

    modport slave (
        input  Data, DataValid, Take, FLUSH, FLUSH_ADDR,
        output Ready, Q, QValid, FETCH_ADDR, LEVEL
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction fetch FIFO with ROM address counter and branch flush.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         ENABLE,
    fetch_queue_if.slave fq
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              full_s;
    logic              empty_s;
    logic              ready_s;
    logic              push_s;
    logic              bypass_s;
    logic              consume_s;
    logic              write_s;
    logic              pop_s;
    logic              qvalid_s;
    logic [DATA_W-1:0] byp_data_s;
    logic [DATA_W-1:0] q_s;

    // Handshake decode: occupancy flags, accept/consume strobes and head byte.
    always_comb begin
        full_s  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                  (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
        empty_s = (wptr_q == rptr_q);
        // Full blocks Ready even if decode pops now: no Take->Ready path.
        ready_s = RESET_N & ENABLE & ~full_s & ~fq.FLUSH;
        push_s  = fq.DataValid & ready_s;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s   = empty_s & push_s;
        byp_data_s = fq.Data;
`else
        bypass_s   = 1'b0;
        byp_data_s = {DATA_W{1'b0}};
`endif
        qvalid_s  = RESET_N & (~empty_s | bypass_s);
        consume_s = bypass_s & fq.Take & ENABLE;
        write_s   = push_s & ~consume_s;
        pop_s     = qvalid_s & fq.Take & ENABLE & ~fq.FLUSH & ~bypass_s;
        if (!qvalid_s) begin
            q_s = {DATA_W{1'b0}};
        end else if (empty_s) begin
            q_s = byp_data_s;
        end else begin
            q_s = mem_q[rptr_q[IDX_W-1:0]];
        end
    end

    // Next-state: flush reloads the address and empties the queue, dropping any push/pop.
    always_comb begin
        if (fq.FLUSH) begin
            wptr_d = {PTR_W{1'b0}};
            rptr_d = {PTR_W{1'b0}};
            addr_d = fq.FLUSH_ADDR;
        end else begin
            wptr_d = write_s ? (wptr_q + PTR_ONE) : wptr_q;
            rptr_d = pop_s ? (rptr_q + PTR_ONE) : rptr_q;
            addr_d = push_s ? (addr_q + ADDR_ONE) : addr_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (write_s && !fq.FLUSH && (wptr_q[IDX_W-1:0] == IDX_W'(i))) ?
                       fq.Data : mem_q[i];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            addr_q <= {ADDR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            addr_q <= addr_d;
            mem_q  <= mem_d;
        end
    end

    assign fq.Ready      = ready_s;
    assign fq.QValid     = qvalid_s;
    assign fq.Q          = q_s;
    assign fq.FETCH_ADDR = addr_q;
    assign fq.LEVEL      = wptr_q - rptr_q;
endmodule
